// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory req/ack, decode valid/ready and redirect.
// The master modport is the fetch unit's view; slave is memory/decode/branch side.
interface inst_fetch_if #(
  parameter int Width = 32
);
  logic             imem_req;
  logic [Width-1:0] imem_addr;
  logic             imem_ack;
  logic [Width-1:0] imem_rdata;
  logic             inst_valid;
  logic             inst_ready;
  logic [Width-1:0] Instruction;
  logic [Width-1:0] inst_pc;
  logic             redirect;
  logic [Width-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, Instruction, inst_pc,
    input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, Instruction, inst_pc,
    output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, fetches words over req/ack and hands
// them to decode over valid/ready; redirects may land while a request is open.
module inst_fetch #(
  parameter int               Width   = 32,
  parameter logic [Width-1:0] ResetPC = '0
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, DRAIN} state_t;

  localparam logic [Width-1:0] Step = Width'(4);
  localparam logic [Width-1:0] Mask = ~Width'(3);

  state_t           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic [Width-1:0] drain_q, drain_d;
  logic [Width-1:0] instr_q, instr_d;
  logic [Width-1:0] ipc_q, ipc_d;
  logic [Width-1:0] redir_pc;

  assign redir_pc = bus.redirect_pc & Mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= ResetPC;
      drain_q <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect) pc_d = redir_pc;
        state_d = REQ;
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (bus.redirect) begin
            pc_d = redir_pc;
          end else begin
            instr_d = bus.imem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + Step;
            state_d = VALID;
          end
        end else if (bus.redirect) begin
          // The open request must still complete at its original address.
          drain_d = pc_q;
          pc_d    = redir_pc;
          state_d = DRAIN;
        end
      end
      VALID: begin
        if (bus.redirect) begin
          pc_d    = redir_pc;
          state_d = REQ;
        end else if (bus.inst_ready) begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (bus.redirect) pc_d = redir_pc;
        if (bus.imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req   = (state_q == REQ) || (state_q == DRAIN);
    bus.imem_addr  = (state_q == DRAIN) ? drain_q : pc_q;
    bus.inst_valid = (state_q == VALID);
  end

  assign bus.Instruction = instr_q;
  assign bus.inst_pc     = ipc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Cycle-scripted stimulus for inst_fetch with queue-based scoreboards for
// memory request addresses and delivered instructions.
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_if #(.Width(32)) bus();

  inst_fetch #(.Width(32), .ResetPC(32'h100)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } dec_t;

  dec_t        exp_dec[$];
  logic [31:0] exp_addr[$];
  int checks = 0;
  int failures = 0;
  int delay = 0;
  int cnt = 0;
  logic force_ack = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h100: return 32'h00500093;
      32'h104: return 32'h00A00113;
      default: return a ^ 32'h5A5A0013;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_dec(input logic [31:0] pc);
    dec_t d;
    d.ins = mem(pc);
    d.pc  = pc;
    exp_dec.push_back(d);
  endtask

  task automatic step(input logic r, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    bus.inst_ready  = r;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
  endtask

  // Memory model: acks after `delay` wait cycles of a continuous request.
  always @(negedge clk) begin
    #1;
    if (force_ack) begin
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEADBEEF; cnt = 0;
    end else if (rst || !bus.imem_req) begin
      bus.imem_ack = 1'b0; cnt = 0;
    end else if (cnt >= delay) begin
      bus.imem_ack = 1'b1; bus.imem_rdata = mem(bus.imem_addr); cnt = 0;
    end else begin
      bus.imem_ack = 1'b0; cnt++;
    end
  end

  // Monitor: pops scoreboards on completed memory requests and decode transfers.
  logic        have_prev = 1'b0;
  logic        p_req, p_ack, p_valid, p_ready, p_redir;
  logic [31:0] p_addr, p_ins, p_pc;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (bus.imem_req && bus.imem_ack) begin
        if (exp_addr.size() == 0) chk("unexpected_ack_addr", bus.imem_addr, 32'hFFFF_FFFF);
        else chk("ack_addr", bus.imem_addr, exp_addr.pop_front());
      end
      if (bus.inst_valid && bus.inst_ready && !bus.redirect) begin
        if (exp_dec.size() == 0) begin
          chk("unexpected_inst", bus.inst_pc, 32'hFFFF_FFFF);
        end else begin
          dec_t d;
          d = exp_dec.pop_front();
          chk("instruction", bus.Instruction, d.ins);
          chk("inst_pc", bus.inst_pc, d.pc);
        end
      end
      if (have_prev && p_req && !p_ack) begin
        chk("req_hold", {31'd0, bus.imem_req}, 32'd1);
        chk("addr_hold", bus.imem_addr, p_addr);
      end
      if (have_prev && p_valid && !p_ready && !p_redir) begin
        chk("valid_hold", {31'd0, bus.inst_valid}, 32'd1);
        chk("instr_hold", bus.Instruction, p_ins);
        chk("pc_hold", bus.inst_pc, p_pc);
        chk("no_req_in_valid", {31'd0, bus.imem_req}, 32'd0);
      end
      p_req = bus.imem_req;  p_ack = bus.imem_ack;  p_addr = bus.imem_addr;
      p_valid = bus.inst_valid; p_ready = bus.inst_ready; p_redir = bus.redirect;
      p_ins = bus.Instruction; p_pc = bus.inst_pc;
      have_prev = 1'b1;
    end
  end

  initial begin
    bus.inst_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;

    // Hand-derived fetch order for the script below.
    exp_addr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h240, 32'h244,
                 32'h200, 32'h204, 32'hFFFFFFFC, 32'h0, 32'h100};
    push_dec(32'h100); push_dec(32'h104); push_dec(32'h108); push_dec(32'h10C);
    push_dec(32'h240); push_dec(32'h200); push_dec(32'hFFFFFFFC); push_dec(32'h0);
    push_dec(32'h100);

    @(negedge clk); @(negedge clk); #1;
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h100);
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_instr", bus.Instruction, 32'h0);
    chk("rst_pc", bus.inst_pc, 32'h0);

    step(1, 0, 0); rst = 1'b0; #3;
    chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
    step(1, 0, 0); #3;                                    // first REQ
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h100);
    repeat (3) step(1, 0, 0);                             // 0x100, 0x104 delivered
    step(0, 0, 0);                                        // REQ 0x108
    repeat (5) step(0, 0, 0);                             // stall in VALID
    step(1, 0, 0); delay = 3;                             // release 0x108
    repeat (5) step(1, 0, 0);                             // 0x10C with 3 waits
    step(1, 1, 32'h200);                                  // REQ 0x110 -> DRAIN
    step(1, 0, 0);
    step(1, 1, 32'h240);                                  // latest redirect wins
    step(1, 0, 0);                                        // drain ack, discarded
    step(1, 0, 0); delay = 0;                             // REQ 0x240
    step(1, 0, 0);
    step(1, 1, 32'h203);                                  // ack+redirect at 0x244
    repeat (3) step(1, 0, 0);                             // 0x200, then REQ 0x204
    step(1, 1, 32'hFFFFFFFC);                             // redirect beats ready
    repeat (4) step(1, 0, 0);                             // 0xFFFFFFFC, wrap to 0
    step(1, 0, 0); delay = 5;                             // REQ 0x4 pending
    #5 rst = 1'b1; #1;
    chk("midrst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("midrst_addr", bus.imem_addr, 32'h100);
    chk("midrst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("midrst_instr", bus.Instruction, 32'h0);
    step(1, 0, 0);
    step(1, 0, 0); rst = 1'b0; force_ack = 1'b1; #3;      // stray ack in IDLE
    chk("late_ack_req", {31'd0, bus.imem_req}, 32'd0);
    chk("late_ack_valid", {31'd0, bus.inst_valid}, 32'd0);
    step(1, 0, 0); force_ack = 1'b0; delay = 0; #3;
    chk("refetch_req", {31'd0, bus.imem_req}, 32'd1);
    chk("refetch_addr", bus.imem_addr, 32'h100);
    step(1, 0, 0);
    step(0, 0, 0); delay = 100;
    step(0, 0, 0);
    #3;
    chk("addr_queue_empty", exp_addr.size(), 32'd0);
    chk("dec_queue_empty", exp_dec.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
